// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexed common-anode 7-seg driver with frame-synchronous commit, dead-time and leading-zero blanking
module seven_seg_scan #(
  parameter int NUM_DIGITS    = 4,
  parameter int SLOT_CYCLES   = 24000,
  parameter int DEAD_CYCLES   = 240,
  parameter int EN_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lzb,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   en,
  output logic                    pending,
  output logic                    frame_done
);
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] EN_OFF = {NUM_DIGITS{EN_ACTIVE_LOW != 0}};
  localparam logic [16*7-1:0] LUT = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0001100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] shadow, buf_digits;
  logic [NUM_DIGITS-1:0]   shadow_dp, buf_dp;
  logic                    slot_end, boundary, dead, blank;
  logic [3:0]              nib;
  logic [6:0]              seg_d;
  assign slot_end = cnt == CNT_LAST;
  assign boundary = slot_end && idx == IDX_LAST;
  assign dead     = cnt < CW'(DEAD_CYCLES);
  assign nib      = shadow[{idx, 2'b00} +: 4];
  // blank when this nibble and everything above it is zero; digit 0 always shows
  assign blank    = lzb && idx != '0 && (shadow >> {idx, 2'b00}) == '0;
  assign seg_d    = blank ? 7'h7f : LUT[7*nib +: 7];
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      buf_digits <= '0;
      buf_dp     <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      seg        <= 7'h7f;
      dp_n       <= 1'b1;
      en         <= EN_OFF;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= idx == IDX_LAST ? '0 : idx + 1'b1;
      if (load) begin
        buf_digits <= digits_in;
        buf_dp     <= dp_in;
      end
      // a load landing on the boundary bypasses the pending buffer
      if (boundary && (load || pending)) begin
        shadow    <= load ? digits_in : buf_digits;
        shadow_dp <= load ? dp_in : buf_dp;
      end
      pending    <= !boundary && (load || pending);
      frame_done <= boundary;
      seg        <= dead ? 7'h7f : seg_d;
      dp_n       <= dead || !shadow_dp[idx];
      en         <= dead ? EN_OFF : EN_OFF ^ (NUM_DIGITS'(1) << idx);
    end
  end
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: scoreboard bench; expectations keyed by cycle, checked by a negedge monitor
module tb_seven_seg_scan;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] Z  = 7'b0000001;
  typedef struct {
    int         c;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] en;
    logic       pend;
    logic       fd;
  } exp_t;
  logic        clk = 0, reset, load, lzb;
  logic [15:0] digits_in;
  logic [3:0]  dp_in, en;
  logic [6:0]  seg;
  logic        dp_n, pending, frame_done;
  int          cyc = 0, checks = 0, failures = 0;
  bit          seen_one = 0;
  exp_t        q[$];
  seven_seg_scan #(.NUM_DIGITS(4), .SLOT_CYCLES(8), .DEAD_CYCLES(2), .EN_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .load(load), .digits_in(digits_in), .dp_in(dp_in), .lzb(lzb),
    .seg(seg), .dp_n(dp_n), .en(en), .pending(pending), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(int k, logic [6:0] s, logic d, logic [3:0] e, logic p, logic f);
    exp_t x;
    x.c = k + 4; x.seg = s; x.dp = d; x.en = e; x.pend = p; x.fd = f;
    q.push_back(x);
  endtask
  task automatic at(int k);
    while (cyc < k + 4) @(negedge clk);
  endtask
  task automatic pulse(logic [15:0] d, logic [3:0] p);
    load = 1; digits_in = d; dp_in = p;
    @(negedge clk);
    load = 0;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (cyc >= 100 && cyc <= 131 && seg == 7'b1001111) seen_one = 1;
    while (q.size() > 0 && q[0].c <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.c < cyc || seg !== e.seg || dp_n !== e.dp || en !== e.en || pending !== e.pend || frame_done !== e.fd) begin
        failures++;
        $display("FAIL c%0d at cyc %0d got seg=%b dp_n=%b en=%b pend=%b fd=%b want seg=%b dp_n=%b en=%b pend=%b fd=%b",
                 e.c, cyc, seg, dp_n, en, pending, frame_done, e.seg, e.dp, e.en, e.pend, e.fd);
      end
    end
  end
  initial begin
    #20000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end
  initial begin
    reset = 1; load = 0; lzb = 0; digits_in = '0; dp_in = '0;
    chk(-3, BL, 1, 4'b1111, 0, 0);
    chk(0, BL, 1, 4'b1111, 0, 0);
    chk(1, BL, 1, 4'b1111, 0, 0);
    chk(2, Z, 1, 4'b1110, 0, 0);
    chk(7, Z, 1, 4'b1110, 0, 0);
    chk(8, BL, 1, 4'b1111, 0, 0);
    chk(9, BL, 1, 4'b1111, 0, 0);
    chk(10, Z, 1, 4'b1101, 0, 0);
    chk(31, Z, 1, 4'b0111, 0, 1);
    chk(32, BL, 1, 4'b1111, 0, 0);
    while (cyc < 3) @(negedge clk);
    reset = 0;
    chk(39, Z, 1, 4'b1110, 0, 0);
    chk(40, BL, 1, 4'b1111, 1, 0);
    chk(42, Z, 1, 4'b1101, 1, 0);
    chk(62, Z, 1, 4'b0111, 1, 0);
    chk(63, Z, 1, 4'b0111, 0, 1);
    at(39); pulse(16'h1A3F, 4'b0100);
    chk(64, BL, 1, 4'b1111, 0, 0);
    chk(66, 7'b0111000, 1, 4'b1110, 0, 0);
    chk(70, 7'b0111000, 1, 4'b1110, 1, 0);
    chk(74, 7'b0000110, 1, 4'b1101, 1, 0);
    chk(80, BL, 1, 4'b1111, 1, 0);
    chk(82, 7'b0001000, 0, 4'b1011, 1, 0);
    chk(90, 7'b1001111, 1, 4'b0111, 1, 0);
    chk(95, 7'b1001111, 1, 4'b0111, 0, 1);
    at(69); pulse(16'h0001, 4'b0000);
    at(79); pulse(16'h0002, 4'b0000);
    chk(98, 7'b0010010, 1, 4'b1110, 0, 0);
    chk(100, 7'b0010010, 1, 4'b1110, 1, 0);
    chk(106, Z, 1, 4'b1101, 1, 0);
    chk(122, Z, 1, 4'b0111, 1, 0);
    chk(127, Z, 1, 4'b0111, 0, 1);
    at(99); pulse(16'h0000, 4'b0000);
    chk(130, Z, 1, 4'b1110, 0, 0);
    chk(138, BL, 1, 4'b1101, 0, 0);
    chk(140, BL, 1, 4'b1101, 1, 0);
    chk(146, BL, 1, 4'b1011, 1, 0);
    chk(154, BL, 1, 4'b0111, 1, 0);
    chk(159, BL, 1, 4'b0111, 0, 1);
    chk(162, Z, 1, 4'b1110, 0, 0);
    chk(170, 7'b0100100, 1, 4'b1101, 0, 0);
    chk(178, BL, 0, 4'b1011, 0, 0);
    chk(186, BL, 1, 4'b0111, 0, 0);
    at(127); lzb = 1;
    at(139); pulse(16'h0050, 4'b0100);
    chk(222, BL, 1, 4'b0111, 0, 0);
    chk(223, BL, 1, 4'b0111, 0, 1);
    chk(224, BL, 1, 4'b1111, 0, 0);
    chk(226, 7'b0001100, 0, 4'b1110, 0, 0);
    chk(234, BL, 1, 4'b1101, 0, 0);
    at(222); pulse(16'h0009, 4'b0001);
    chk(236, BL, 1, 4'b1101, 1, 0);
    chk(242, BL, 1, 4'b1011, 1, 0);
    chk(243, BL, 1, 4'b1011, 1, 0);
    chk(244, BL, 1, 4'b1111, 0, 0);
    chk(245, BL, 1, 4'b1111, 0, 0);
    chk(247, Z, 1, 4'b1110, 0, 0);
    chk(255, BL, 1, 4'b1101, 0, 0);
    chk(276, BL, 1, 4'b0111, 0, 1);
    chk(279, Z, 1, 4'b1110, 0, 0);
    at(235); pulse(16'h4444, 4'b0000);
    at(243); reset = 1;
    @(negedge clk); reset = 0;
    at(290);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d left want 0", q.size());
    end
    checks++;
    if (seen_one) begin
      failures++;
      $display("FAIL last_write_wins got seg=1001111 seen want never");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Parametrised multiplexed driver for NUM_DIGITS common-anode seven-segment digits sharing one segment bus.
- Latches a packed hex word through a double-buffered load interface and commits it only at frame boundaries, so no digit tears mid-frame.
- Scans one digit per slot, with a blanking dead-time between digits, plus per-digit decimal point and optional leading-zero blanking.
- Sits between the application datapath and the board pins, in place of single-digit decode plus hand-built enable toggling.

Parameters:
- NUM_DIGITS, 4: digits on the bus; range 1..8.
- SLOT_CYCLES, 24000: clk cycles per digit slot; at least 2.
- DEAD_CYCLES, 240: leading cycles of each slot with all enables off; 0 ≤ DEAD_CYCLES < SLOT_CYCLES.
- EN_ACTIVE_LOW, 1: 1 means en outputs are driven low to select a digit.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- load  input  1  single-cycle strobe; capture digits_in/dp_in into pending buffer
- digits_in  input  4*NUM_DIGITS  hex nibbles; nibble k = digit k, digit 0 least significant
- dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit
- lzb  input  1  leading-zero blank enable (level, sampled every cycle)
- seg  output  7  active-low segments; seg[6]=a … seg[0]=g
- dp_n  output  1  active-low decimal point of the enabled digit
- en  output  NUM_DIGITS  digit enables, polarity per EN_ACTIVE_LOW
- pending  output  1  high while a loaded value awaits commit
- frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Clock and reset: single clock domain, clk; reset is synchronous and active-high. All outputs are registered.
- Reset state: seg=7'b1111111, dp_n=1, en all inactive, pending=0, frame_done=0.
- Reset internal state: slot counter cnt=0, digit index idx=0, shadow and pending buffers cleared to 0.
- Reset mid-slot or mid-load: discards any pending value and the shadow contents.
- Timing reference: the output register in cycle t+1 reflects cnt/idx of cycle t.
- Slot counter: cnt counts 0..SLOT_CYCLES-1, then wraps to 0 and increments idx. idx wraps from NUM_DIGITS-1 to 0.
- Frame boundary: cycle where cnt=SLOT_CYCLES-1 and idx=NUM_DIGITS-1.
  - frame_done is asserted in the following cycle.
- Per-slot phases:
  - DEAD phase, cnt < DEAD_CYCLES: en all inactive, seg all 1, dp_n=1.
  - DRIVE phase, cnt ≥ DEAD_CYCLES: only en[idx] active; seg = decode of shadow nibble idx; dp_n = ~shadow_dp[idx].
- Decode table (seg[6:0], active low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0001100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Leading-zero blank, when lzb=1:
  - Digit k is blanked (seg=1111111) if its nibble and every more-significant nibble are 0.
  - Digit 0 is never blanked.
  - dp_n still follows shadow_dp.
  - en still asserts for a blanked digit, keeping the duty cycle constant.
- Load handshake (always accepted, never stalls):
  - load=1 writes digits_in/dp_in to the pending buffer and sets pending.
  - A later load before commit overwrites the buffer (last write wins).
- Commit: at a frame boundary with pending=1, pending copies to shadow and pending clears.
  - The new value first appears in the slot starting the next cycle (digit 0).
- load coinciding with a frame boundary: digits_in commits directly to shadow, and pending stays/ends 0.
- Width rules:
  - cnt width = $clog2(SLOT_CYCLES).
  - idx width = max(1, $clog2(NUM_DIGITS)).
  - When NUM_DIGITS=1, idx is constant 0 and every slot end is a frame boundary.
- DEAD_CYCLES=0: en never goes inactive between digits; the en change and the seg change occur in the same output cycle.

Test Plan:
- Common bench configuration: NUM_DIGITS=4, SLOT_CYCLES=8, DEAD_CYCLES=2, EN_ACTIVE_LOW=1.
- Reset: hold reset 3 cycles → seg=1111111, dp_n=1, en=4'b1111, pending=0. After release: en=4'b1111 for 2 cycles, then en=4'b1110 for 6 cycles, then en=4'b1111 for 2, then en=4'b1101.
- Load/commit: load digits_in=16'h1A3F, dp_in=4'b0100 mid-frame → pending=1 until the boundary; frame_done pulses once per 32 cycles. Next frame shows digit0 seg=0111000, digit1 0000110, digit2 0001000 with dp_n=0, digit3 1001111.
- Last write wins: two loads (16'h0001, then 16'h0002) in one frame → only 2 is ever displayed; 1 never appears on seg.
- Leading-zero blanking: shadow=16'h0000 with lzb=1 → digits 3..1 seg=1111111, digit0 seg=0000001. With shadow=16'h0050 → digits 3,2 blank, digits 1,0 show 5 and 0.
- Boundary load and reset abort: load on the exact frame-boundary cycle → value visible on digit 0 next cycle, pending stays 0. Reset asserted during the DRIVE phase of digit 2 → next cycle outputs all off and idx restarts at 0.
